// File: rtl/knight_cmd_exec.sv
// Command responder: accepts cmd words, runs calibrate or heading-then-line-counted moves, pulses send_resp.
// Optional MOVE watchdog enabled by defining CMD_TIMEOUT_EN.
module knight_cmd_exec #(
   parameter int          LINES_PER_SQ = 2,
   parameter logic [23:0] TIMEOUT_CYC  = 24'd10_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cmd,
   input  logic        cmd_rdy,
   output logic        clr_cmd_rdy,
   output logic        send_resp,
   output logic        strt_cal,
   input  logic        cal_done,
   input  logic        heading_ok,
   input  logic        cntrIR,
   output logic [11:0] desired_heading,
   output logic        moving,
   output logic        fanfare,
   output logic        timeout_err
);

   typedef enum logic [2:0] {IDLE, CAL_WAIT, HEAD, MOVE, RESP} state_t;

   localparam logic [3:0] OP_CAL      = 4'b0000;
   localparam logic [3:0] OP_MOVE     = 4'b0010;
   localparam logic [3:0] OP_MOVE_FAN = 4'b0011;

   state_t      state_q, state_d;
   logic [3:0]  opcode_q, opcode_d;
   logic [4:0]  target_q, target_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [11:0] heading_q, heading_d;
   logic        moving_q, moving_d;
   logic        send_resp_q, send_resp_d;
   logic        strt_cal_q, strt_cal_d;
   logic        fanfare_q, fanfare_d;
   logic [2:0]  ir_sync_q, ir_sync_d;
   logic        ir_rise;

`ifdef CMD_TIMEOUT_EN
   logic [23:0] wdog_q, wdog_d;
   logic        timeout_q, timeout_d;
   assign timeout_err = timeout_q;
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
   assign timeout_err = 1'b0;
`endif

   // bits [1:0] form the synchronizer; bit 2 is the previous synchronized level
   assign ir_sync_d = {ir_sync_q[1:0], cntrIR};
   assign ir_rise   = ir_sync_q[1] & ~ir_sync_q[2];

   always_comb begin
      state_d     = state_q;
      opcode_d    = opcode_q;
      target_d    = target_q;
      cnt_d       = cnt_q;
      heading_d   = heading_q;
      moving_d    = moving_q;
      send_resp_d = 1'b0;
      strt_cal_d  = 1'b0;
      fanfare_d   = 1'b0;
      clr_cmd_rdy = 1'b0;
`ifdef CMD_TIMEOUT_EN
      wdog_d      = wdog_q;
      timeout_d   = timeout_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_rdy) begin
               clr_cmd_rdy = 1'b1;
               opcode_d    = cmd[15:12];
               target_d    = 5'(cmd[3:0] * LINES_PER_SQ);
               case (cmd[15:12])
                  OP_CAL: begin
                     strt_cal_d = 1'b1;
                     state_d    = CAL_WAIT;
                  end
                  OP_MOVE, OP_MOVE_FAN: begin
                     heading_d = (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
                     state_d   = HEAD;
                  end
                  default: begin
                     send_resp_d = 1'b1;
                     state_d     = RESP;
                  end
               endcase
            end
         end
         CAL_WAIT: begin
            if (cal_done) begin
               send_resp_d = 1'b1;
               state_d     = RESP;
            end
         end
         HEAD: begin
            if (heading_ok) begin
               if (target_q == 5'd0) begin
                  send_resp_d = 1'b1;
                  fanfare_d   = (opcode_q == OP_MOVE_FAN);
                  state_d     = RESP;
               end else begin
                  cnt_d    = 5'd0;
                  moving_d = 1'b1;
                  state_d  = MOVE;
`ifdef CMD_TIMEOUT_EN
                  wdog_d   = 24'd0;
`endif
               end
            end
         end
         MOVE: begin
            if (ir_rise) begin
               cnt_d = cnt_q + 5'd1;
`ifdef CMD_TIMEOUT_EN
               wdog_d = 24'd0;
`endif
               if (cnt_q + 5'd1 == target_q) begin
                  moving_d    = 1'b0;
                  send_resp_d = 1'b1;
                  fanfare_d   = (opcode_q == OP_MOVE_FAN);
                  state_d     = RESP;
               end
            end
`ifdef CMD_TIMEOUT_EN
            else if (wdog_q == TIMEOUT_CYC - 24'd1) begin
               // a stalled move still completes its handshake, just without celebration
               moving_d    = 1'b0;
               timeout_d   = 1'b1;
               send_resp_d = 1'b1;
               state_d     = RESP;
            end else begin
               wdog_d = wdog_q + 24'd1;
            end
`endif
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         opcode_q    <= 4'd0;
         target_q    <= 5'd0;
         cnt_q       <= 5'd0;
         heading_q   <= 12'h000;
         moving_q    <= 1'b0;
         send_resp_q <= 1'b0;
         strt_cal_q  <= 1'b0;
         fanfare_q   <= 1'b0;
         ir_sync_q   <= 3'b000;
`ifdef CMD_TIMEOUT_EN
         wdog_q      <= 24'd0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         opcode_q    <= opcode_d;
         target_q    <= target_d;
         cnt_q       <= cnt_d;
         heading_q   <= heading_d;
         moving_q    <= moving_d;
         send_resp_q <= send_resp_d;
         strt_cal_q  <= strt_cal_d;
         fanfare_q   <= fanfare_d;
         ir_sync_q   <= ir_sync_d;
`ifdef CMD_TIMEOUT_EN
         wdog_q      <= wdog_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign send_resp       = send_resp_q;
   assign strt_cal        = strt_cal_q;
   assign fanfare         = fanfare_q;
   assign moving          = moving_q;
   assign desired_heading = heading_q;

endmodule

// File: tb/tb_knight_cmd_exec.sv
// Directed bench for knight_cmd_exec: move, move with fanfare, calibrate, rotate-only,
// pending command during MOVE, reset mid-move, and the watchdog when CMD_TIMEOUT_EN is defined.
module tb_knight_cmd_exec;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cmd = 16'h0000;
   logic        cmd_rdy = 1'b0;
   logic        clr_cmd_rdy, send_resp, strt_cal, moving, fanfare, timeout_err;
   logic        cal_done = 1'b0;
   logic        heading_ok = 1'b0;
   logic        cntrIR = 1'b0;
   logic [11:0] desired_heading;

   int checks = 0;
   int errors = 0;
   int resp_cnt = 0, fan_cnt = 0, cal_cnt = 0, both_cnt = 0, mov_cnt = 0, clr_cnt = 0;
   int r0, f0, c0, b0, m0, k0;
   int waited;
   logic ok;

   knight_cmd_exec #(.LINES_PER_SQ(2), .TIMEOUT_CYC(24'd100)) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
      .send_resp(send_resp), .strt_cal(strt_cal), .cal_done(cal_done), .heading_ok(heading_ok),
      .cntrIR(cntrIR), .desired_heading(desired_heading), .moving(moving), .fanfare(fanfare),
      .timeout_err(timeout_err)
   );

   always #10 clk = ~clk;

   // pulse counters sampled mid-cycle
   always @(negedge clk) begin
      resp_cnt <= resp_cnt + int'(send_resp);
      fan_cnt  <= fan_cnt + int'(fanfare);
      cal_cnt  <= cal_cnt + int'(strt_cal);
      both_cnt <= both_cnt + int'(send_resp & fanfare);
      mov_cnt  <= mov_cnt + int'(moving);
      clr_cnt  <= clr_cnt + int'(clr_cmd_rdy);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      r0 = resp_cnt; f0 = fan_cnt; c0 = cal_cnt; b0 = both_cnt; m0 = mov_cnt; k0 = clr_cnt;
   endtask

   // raise cmd_rdy, wait for the accept pulse, then drop cmd_rdy after the accepting edge
   task automatic accept(input logic [15:0] word, input int budget, output int n, output logic found);
      cmd = word;
      cmd_rdy = 1'b1;
      #1;
      found = 1'b0;
      n = 0;
      while (!found && n < budget) begin
         if (clr_cmd_rdy) found = 1'b1;
         else begin
            tick(1);
            n++;
         end
      end
      tick(1);
      cmd_rdy = 1'b0;
      $display("txn cmd=%h accepted=%0d after %0d cycles", word, found, n);
   endtask

   task automatic ir_edge();
      cntrIR = 1'b1;
      tick(3);
      cntrIR = 1'b0;
      tick(3);
   endtask

   initial begin
      tick(2);
      check("rst_clr", clr_cmd_rdy, 0);
      check("rst_resp", send_resp, 0);
      check("rst_cal", strt_cal, 0);
      check("rst_moving", moving, 0);
      check("rst_fan", fanfare, 0);
      check("rst_heading", desired_heading, 12'h000);
      check("rst_timeout", timeout_err, 0);
      rst_n = 1'b1;
      tick(2);

      // MOVE north two squares
      heading_ok = 1'b1;
      snap();
      accept(16'h2002, 10, waited, ok);
      check("t1_accept", ok, 1);
      check("t1_clr_same_cycle", waited, 0);
      check("t1_heading", desired_heading, 12'h000);
      tick(1);
      check("t1_moving", moving, 1);
      repeat (3) ir_edge();
      check("t1_still_moving", moving, 1);
      check("t1_no_resp_yet", resp_cnt - r0, 0);
      ir_edge();
      check("t1_stopped", moving, 0);
      check("t1_resp", resp_cnt - r0, 1);
      check("t1_fan", fan_cnt - f0, 0);
      tick(2);

      // MOVE_FAN west one square with delayed heading
      heading_ok = 1'b0;
      snap();
      accept(16'h33F1, 10, waited, ok);
      check("t2_accept", ok, 1);
      tick(50);
      check("t2_no_move", mov_cnt - m0, 0);
      check("t2_heading", desired_heading, 12'h3FF);
      heading_ok = 1'b1;
      tick(1);
      check("t2_moving", moving, 1);
      repeat (2) ir_edge();
      check("t2_resp", resp_cnt - r0, 1);
      check("t2_fan_with_resp", both_cnt - b0, 1);
      check("t2_stopped", moving, 0);
      tick(2);

      // CAL
      snap();
      accept(16'h0000, 10, waited, ok);
      check("t3_accept", ok, 1);
      tick(5);
      check("t3_strt_cal", cal_cnt - c0, 1);
      check("t3_no_resp", resp_cnt - r0, 0);
      cal_done = 1'b1;
      tick(1);
      cal_done = 1'b0;
      tick(2);
      check("t3_resp", resp_cnt - r0, 1);
      check("t3_heading_held", desired_heading, 12'h3FF);

      // rotate-only east; an IR edge while heading is ignored
      heading_ok = 1'b0;
      snap();
      accept(16'h2BF0, 10, waited, ok);
      check("t4_accept", ok, 1);
      ir_edge();
      check("t4_heading", desired_heading, 12'hBFF);
      check("t4_no_resp", resp_cnt - r0, 0);
      heading_ok = 1'b1;
      tick(3);
      check("t4_resp", resp_cnt - r0, 1);
      check("t4_never_moved", mov_cnt - m0, 0);

      // unknown opcode pending during MOVE
      snap();
      accept(16'h2001, 10, waited, ok);
      tick(1);
      check("t5_moving", moving, 1);
      cmd = 16'h5000;
      cmd_rdy = 1'b1;
      tick(5);
      check("t5_not_cleared", clr_cmd_rdy, 0);
      check("t5_clr_cnt", clr_cnt - k0, 1);
      ir_edge();
      cntrIR = 1'b1;
      accept(16'h5000, 20, waited, ok);
      check("t5_pending_accept", ok, 1);
      check("t5_resp_before_clr", resp_cnt - r0, 1);
      cntrIR = 1'b0;
      tick(4);
      check("t5_resp_total", resp_cnt - r0, 2);
      check("t5_clr_total", clr_cnt - k0, 2);
      check("t5_no_motion_unknown", moving, 0);

      // reset taken mid-MOVE
      accept(16'h2C03, 10, waited, ok);
      tick(1);
      check("t6_moving", moving, 1);
      ir_edge();
      snap();
      rst_n = 1'b0;
      #1;
      check("t6_rst_moving", moving, 0);
      check("t6_rst_heading", desired_heading, 12'h000);
      tick(2);
      rst_n = 1'b1;
      tick(5);
      check("t6_no_resp", resp_cnt - r0, 0);
      check("t6_still_idle", moving, 0);

`ifdef CMD_TIMEOUT_EN
      snap();
      accept(16'h3001, 10, waited, ok);
      tick(200);
      check("t7_timeout_err", timeout_err, 1);
      check("t7_stopped", moving, 0);
      check("t7_move_cycles", mov_cnt - m0, 100);
      check("t7_resp", resp_cnt - r0, 1);
      check("t7_fan", fan_cnt - f0, 0);
`else
      snap();
      accept(16'h2001, 10, waited, ok);
      tick(300);
      check("t7_waits", moving, 1);
      check("t7_no_timeout", timeout_err, 0);
      repeat (2) ir_edge();
      check("t7_resp", resp_cnt - r0, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
